// File: rtl/branch_predictor_btb_pkg.sv
// Shared types for the BTB branch predictor: counter encodings, FSM states and entry layout.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {INIT, READY} bp_state_e;

  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_ENTRIES = 16;
  localparam int unsigned DEF_TAG_W   = DEF_XLEN - $clog2(DEF_ENTRIES) - 2;

  // Entry layout at the default geometry; the top builds the same layout at its own widths.
  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_XLEN-1:0]  target;
    logic [1:0]           cnt;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Lookup/update/status bundle between the pipeline and the branch predictor.
interface branch_predictor_btb_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [XLEN-1:0] lk_pc_i;
  logic            lk_hit_o;
  logic            lk_taken_o;
  logic [XLEN-1:0] lk_target_o;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic            upd_pred_taken_i;
  logic [XLEN-1:0] upd_pred_target_i;
  logic            mispredict_o;
  logic            busy_o;
  logic [31:0]     mispred_cnt_o;

  modport master (
    output start_i, lk_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i,
    input  lk_hit_o, lk_taken_o, lk_target_o, mispredict_o, busy_o, mispred_cnt_o
  );

  modport slave (
    input  start_i, lk_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i,
    output lk_hit_o, lk_taken_o, lk_target_o, mispredict_o, busy_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_predictor_btb_sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: zero-latency IF lookup, EXMEM training and
// mispredict detection, plus a valid-clearing walk after reset.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter logic [1:0]  CNT_INIT = WT
) (
  input logic                   clk_i,
  input logic                   rst_i,
  branch_predictor_btb_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       cnt;
  } entry_t;

  entry_t            table_q [ENTRIES];
  bp_state_e         state_q;
  logic [IDX_W-1:0]  clr_idx_q;
  logic [31:0]       mispred_cnt_q;

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  entry_t            lk_entry, up_entry;
  logic              busy, lk_hit, up_hit, accept, mispredict;
  logic [1:0]        up_cnt_next;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^{bus.lk_pc_i[1:0], bus.upd_pc_i[1:0]};

  assign lk_idx   = bus.lk_pc_i[IDX_W+1:2];
  assign lk_tag   = bus.lk_pc_i[XLEN-1:IDX_W+2];
  assign up_idx   = bus.upd_pc_i[IDX_W+1:2];
  assign up_tag   = bus.upd_pc_i[XLEN-1:IDX_W+2];
  assign lk_entry = table_q[lk_idx];
  assign up_entry = table_q[up_idx];

  assign busy   = (state_q == INIT);
  // Gating on valid keeps never-allocated (uninitialised) fields off the outputs.
  assign lk_hit = !busy && lk_entry.valid && (lk_entry.tag == lk_tag);
  assign up_hit = up_entry.valid && (up_entry.tag == up_tag);
  assign accept = (state_q == READY) && bus.upd_valid_i && bus.start_i;

  assign mispredict = bus.upd_valid_i &&
                      ((bus.upd_pred_taken_i != bus.upd_taken_i) ||
                       (bus.upd_taken_i && bus.upd_pred_taken_i &&
                        (bus.upd_pred_target_i != bus.upd_target_i)));

  sat_counter2 u_sat_counter2 (
    .cnt_i   (up_entry.cnt),
    .taken_i (bus.upd_taken_i),
    .cnt_o   (up_cnt_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= INIT;
      clr_idx_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          table_q[clr_idx_q].valid <= 1'b0;
          clr_idx_q                <= clr_idx_q + 1'b1;
          if (clr_idx_q == IDX_W'(ENTRIES - 1)) state_q <= READY;
        end
        READY: begin
          if (accept) begin
            if (up_hit) begin
              table_q[up_idx].cnt <= up_cnt_next;
              if (bus.upd_taken_i) table_q[up_idx].target <= bus.upd_target_i;
            end else if (bus.upd_taken_i) begin
              table_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: bus.upd_target_i,
                                   cnt: CNT_INIT};
            end
            if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign bus.lk_hit_o      = lk_hit;
  assign bus.lk_taken_o    = lk_hit && lk_entry.cnt[1];
  assign bus.lk_target_o   = lk_hit ? lk_entry.target : '0;
  assign bus.mispredict_o  = mispredict;
  assign bus.busy_o        = busy;
  assign bus.mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: init walk, training vectors, aliasing,
// mispredict counting, same-cycle hazard and reset during operation.
module tb_branch_predictor_btb;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_btb_if #(.XLEN(32)) bus ();

  branch_predictor_btb #(
    .XLEN     (32),
    .ENTRIES  (16),
    .CNT_INIT (WT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] lk_pc;
    logic        upd_valid;
    logic        start;
    logic [31:0] upd_pc;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        exp_hit;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  localparam int NV = 18;
  vec_t  vecs [NV];
  exp_t  sb [$];
  int    n_chk  = 0;
  int    n_fail = 0;
  logic [31:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] lk, input logic uv, input logic st,
                               input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                               input logic ptk, input logic [31:0] ptgt, input logic eh,
                               input logic et, input logic [31:0] etgt, input logic em);
    vec_t v;
    v = '{lk, uv, st, upc, tk, tgt, ptk, ptgt, eh, et, etgt, em};
    return v;
  endfunction

  task automatic idle_inputs();
    bus.start_i           = 1'b1;
    bus.upd_valid_i       = 1'b0;
    bus.upd_pc_i          = '0;
    bus.upd_taken_i       = 1'b0;
    bus.upd_target_i      = '0;
    bus.upd_pred_taken_i  = 1'b0;
    bus.upd_pred_target_i = '0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    bus.upd_valid_i       = 1'b1;
    bus.upd_pc_i          = pc;
    bus.upd_taken_i       = tk;
    bus.upd_target_i      = tgt;
    bus.upd_pred_taken_i  = ptk;
    bus.upd_pred_target_i = ptgt;
  endtask

  initial begin
    int         n;
    exp_t       e;
    btb_entry_t trained [4];
    logic [31:0] pc;

    idle_inputs();
    bus.lk_pc_i = 32'h40;

    // Allocate/saturate on 0x40, same-cycle hazard (v5), target mispredict, start gating,
    // alias eviction by 0x80, not-taken miss and upd_valid gating.
    vecs[0]  = mkv(32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   1);
    vecs[1]  = mkv(32'h40, 1, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 1, 32'h100, 0);
    vecs[2]  = mkv(32'h40, 1, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 1, 32'h100, 0);
    vecs[3]  = mkv(32'h40, 1, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 1, 32'h100, 0);
    vecs[4]  = mkv(32'h40, 1, 1, 32'h40, 0, 32'h0,   1, 32'h100, 1, 1, 32'h100, 1);
    vecs[5]  = mkv(32'h40, 1, 1, 32'h40, 0, 32'h0,   1, 32'h100, 1, 1, 32'h100, 1);
    vecs[6]  = mkv(32'h40, 0, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 0, 32'h100, 0);
    vecs[7]  = mkv(32'h40, 1, 1, 32'h40, 1, 32'h104, 1, 32'h100, 1, 0, 32'h100, 1);
    vecs[8]  = mkv(32'h40, 1, 1, 32'h40, 1, 32'h104, 1, 32'h104, 1, 1, 32'h104, 0);
    vecs[9]  = mkv(32'h40, 1, 0, 32'h40, 0, 32'h0,   1, 32'h104, 1, 1, 32'h104, 1);
    vecs[10] = mkv(32'h40, 0, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 1, 32'h104, 0);
    vecs[11] = mkv(32'h80, 1, 1, 32'h80, 1, 32'h200, 0, 32'h0,   0, 0, 32'h0,   1);
    vecs[12] = mkv(32'h40, 0, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0);
    vecs[13] = mkv(32'h80, 0, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 0);
    vecs[14] = mkv(32'h44, 1, 1, 32'h44, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0);
    vecs[15] = mkv(32'h44, 0, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0);
    vecs[16] = mkv(32'h80, 0, 1, 32'h80, 1, 32'h300, 0, 32'h0,   1, 1, 32'h200, 0);
    vecs[17] = mkv(32'h80, 0, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 0);

    // Init walk: reset one cycle, busy for exactly 16 cycles, update in INIT ignored.
    @(negedge clk);
    rst = 1'b0;
    bus.lk_pc_i = 32'h300;
    #1;
    chk("init_cnt", bus.mispred_cnt_o, 32'h0);
    chk("init_hit_busy", {31'b0, bus.lk_hit_o}, 32'h0);
    n = 0;
    while (bus.busy_o === 1'b1 && n < 64) begin
      n++;
      if (n == 5) drive_upd(32'h300, 1'b1, 32'h500, 1'b0, 32'h0);
      else        bus.upd_valid_i = 1'b0;
      @(negedge clk);
      #1;
    end
    idle_inputs();
    chk("init_busy_cycles", n, 16);
    chk("init_busy_low", {31'b0, bus.busy_o}, 32'h0);
    chk("init_upd_ignored_hit", {31'b0, bus.lk_hit_o}, 32'h0);
    chk("init_upd_ignored_cnt", bus.mispred_cnt_o, 32'h0);

    // Table-driven vectors through the scoreboard queue.
    exp_cnt = 32'h0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.lk_pc_i           = vecs[i].lk_pc;
      bus.start_i           = vecs[i].start;
      bus.upd_valid_i       = vecs[i].upd_valid;
      bus.upd_pc_i          = vecs[i].upd_pc;
      bus.upd_taken_i       = vecs[i].taken;
      bus.upd_target_i      = vecs[i].target;
      bus.upd_pred_taken_i  = vecs[i].pred_taken;
      bus.upd_pred_target_i = vecs[i].pred_target;
      sb.push_back('{vecs[i].exp_hit, vecs[i].exp_taken, vecs[i].exp_target,
                     vecs[i].exp_mis, exp_cnt});
      if (vecs[i].upd_valid && vecs[i].start && vecs[i].exp_mis) exp_cnt = exp_cnt + 1;
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d hit", i), {31'b0, bus.lk_hit_o}, {31'b0, e.hit});
      chk($sformatf("v%0d taken", i), {31'b0, bus.lk_taken_o}, {31'b0, e.taken});
      chk($sformatf("v%0d target", i), bus.lk_target_o, e.target);
      chk($sformatf("v%0d mispredict", i), {31'b0, bus.mispredict_o}, {31'b0, e.mis});
      chk($sformatf("v%0d mispred_cnt", i), bus.mispred_cnt_o, e.cnt);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("vec_final_cnt", bus.mispred_cnt_o, exp_cnt);

    // Train four entries (indices 0..3), each a direction mispredict.
    for (int i = 0; i < 4; i++) begin
      trained[i] = '{valid: 1'b1, tag: 26'h40, target: 32'h2000 + 32'(i * 16), cnt: WT};
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pc = {trained[i].tag, 4'(i), 2'b00};
      drive_upd(pc, 1'b1, trained[i].target, 1'b0, 32'h0);
      exp_cnt = exp_cnt + 1;
    end
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.lk_pc_i = {trained[i].tag, 4'(i), 2'b00};
      #1;
      chk($sformatf("train%0d hit", i), {31'b0, bus.lk_hit_o}, 32'h1);
      chk($sformatf("train%0d target", i), bus.lk_target_o, trained[i].target);
    end
    chk("train_cnt", bus.mispred_cnt_o, exp_cnt);

    // Reset asserted during a mispredicting update.
    @(negedge clk);
    rst = 1'b1;
    bus.lk_pc_i = 32'h100c;
    drive_upd(32'h1010, 1'b1, 32'h3000, 1'b0, 32'h0);
    #1;
    chk("rst_mispredict_comb", {31'b0, bus.mispredict_o}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rst_cnt_cleared", bus.mispred_cnt_o, 32'h0);
    chk("rst_hit_gated", {31'b0, bus.lk_hit_o}, 32'h0);
    chk("rst_target_gated", bus.lk_target_o, 32'h0);
    n = 0;
    while (bus.busy_o === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("rst_busy_cycles", n, 16);
    for (int i = 0; i < 5; i++) begin
      bus.lk_pc_i = 32'h1000 + 32'(i * 4);
      #1;
      chk($sformatf("rst_miss%0d", i), {31'b0, bus.lk_hit_o}, 32'h0);
    end
    chk("rst_cnt_after", bus.mispred_cnt_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
